// File: rtl/key_search_scheduler.sv
// Key-space scheduler for a bank of decryption cores: splits 0..KEY_MAX across cores, launches them, reports first hit.
// Optional watchdog enabled by defining SCHED_TIMEOUT_EN.
module key_search_scheduler #(
    parameter int          NUM_CORES      = 4,
    parameter logic [23:0] KEY_MAX        = 24'h3FFFFF,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd100_000_000,
    localparam int         FCW            = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    output logic [NUM_CORES-1:0]    core_reset_n,
    output logic [NUM_CORES-1:0]    core_start,
    output logic [NUM_CORES*24-1:0] core_key_start,
    output logic [NUM_CORES*24-1:0] core_key_end,
    input  logic [NUM_CORES-1:0]    core_done,
    input  logic [NUM_CORES-1:0]    core_found,
    input  logic [NUM_CORES*24-1:0] core_key,
    output logic                    busy,
    output logic                    done,
    output logic                    key_found,
    output logic [23:0]             found_key,
    output logic [FCW-1:0]          found_core,
    output logic                    timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LAUNCH,
        S_SEARCH,
        S_DONE
    } state_t;

    localparam logic [24:0] SPAN = ({1'b0, KEY_MAX} + 25'd1) / 25'(NUM_CORES);

    state_t               state, next_state;
    logic [1:0]           clr_cnt;
    logic                 start_q;
    logic [NUM_CORES-1:0] finished;
    logic                 hit;
    logic [FCW-1:0]       hit_idx;
    logic [23:0]          hit_key;
    logic                 all_done;
    logic                 wd_exp;

    // Static per-core ranges, computed in 25 bits so KEY_MAX+1 cannot wrap.
    for (genvar i = 0; i < NUM_CORES; i++) begin : g_range
        localparam logic [24:0] K_START = 25'(i) * SPAN;
        localparam logic [24:0] K_END   = 25'(i + 1) * SPAN - 25'd1;
        assign core_key_start[i*24 +: 24] = K_START[23:0];
        assign core_key_end[i*24 +: 24]   = K_END[23:0];
    end

`ifdef SCHED_TIMEOUT_EN
    logic [31:0] wdog;

    assign wd_exp = (state == S_SEARCH) && (wdog == TIMEOUT_CYCLES - 32'd1);

    always_ff @(posedge clk) begin
        if (reset || state == S_CLEAR) begin
            wdog <= '0;
        end else if (state == S_SEARCH) begin
            wdog <= wdog + 32'd1;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign wd_exp             = 1'b0;
`endif

    // Scan high to low so the lowest-indexed hit ends up selected.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        hit_key = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (core_done[i] && core_found[i]) begin
                hit     = 1'b1;
                hit_idx = FCW'(i);
                hit_key = core_key[i*24 +: 24];
            end
        end
    end

    assign all_done = &(finished | core_done);
    assign busy     = (state == S_CLEAR) || (state == S_LAUNCH) || (state == S_SEARCH);

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (start_q) next_state = S_CLEAR;
            S_CLEAR:  if (clr_cnt == 2'd1) next_state = S_LAUNCH;
            S_LAUNCH: next_state = S_SEARCH;
            S_SEARCH: if (hit || all_done || wd_exp) next_state = S_DONE;
            S_DONE:   if (start_q) next_state = S_CLEAR;
            default:  next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            clr_cnt      <= '0;
            start_q      <= 1'b0;
            finished     <= '0;
            core_reset_n <= '0;
            core_start   <= '0;
            done         <= 1'b0;
            key_found    <= 1'b0;
            found_key    <= '0;
            found_core   <= '0;
            timeout      <= 1'b0;
        end else begin
            state        <= next_state;
            start_q      <= start;
            // Core controls follow the state being entered, so an abort reaches the cores immediately.
            core_start   <= {NUM_CORES{next_state == S_LAUNCH}};
            core_reset_n <= {NUM_CORES{(next_state == S_LAUNCH) || (next_state == S_SEARCH)}};

            if (next_state == S_CLEAR && state != S_CLEAR) begin
                clr_cnt    <= '0;
                finished   <= '0;
                done       <= 1'b0;
                key_found  <= 1'b0;
                found_key  <= '0;
                found_core <= '0;
                timeout    <= 1'b0;
            end else if (state == S_CLEAR) begin
                clr_cnt <= clr_cnt + 2'd1;
            end

            if (state == S_SEARCH) begin
                finished <= finished | core_done;
                if (hit) begin
                    done       <= 1'b1;
                    key_found  <= 1'b1;
                    found_key  <= hit_key;
                    found_core <= hit_idx;
                end else if (all_done) begin
                    done <= 1'b1;
                end else if (wd_exp) begin
                    done    <= 1'b1;
                    timeout <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_key_search_scheduler.sv
// Bench for key_search_scheduler: table of search scenarios plus reset/relaunch/watchdog sequences.
module tb_key_search_scheduler;
    localparam int N = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [N-1:0]  core_reset_n, core_start, core_done, core_found;
    logic [N*24-1:0] core_key_start, core_key_end, core_key;
    logic          busy, done, key_found, timeout;
    logic [23:0]   found_key;
    logic [1:0]    found_core;

    key_search_scheduler #(
        .NUM_CORES(N),
        .KEY_MAX(24'h3FFFFF),
        .TIMEOUT_CYCLES(32'd50)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .core_reset_n(core_reset_n), .core_start(core_start),
        .core_key_start(core_key_start), .core_key_end(core_key_end),
        .core_done(core_done), .core_found(core_found), .core_key(core_key),
        .busy(busy), .done(done), .key_found(key_found),
        .found_key(found_key), .found_core(found_core), .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  dmask;
        logic [3:0]  fmask;
        logic [95:0] keys;
        bit          stagger;
        bit          exp_found;
        logic [23:0] exp_key;
        logic [1:0]  exp_core;
    } vec_t;

    typedef struct {
        bit          found;
        logic [23:0] key;
        logic [1:0]  core;
    } res_t;

    vec_t vecs[5];
    res_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Pulses start for one cycle from a negedge and checks the launch timing.
    task automatic launch();
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("cs_k", core_start, 0);
        @(negedge clk);
        chk("busy_clear", busy, 1);
        chk("cs_k1", core_start, 0);
        @(negedge clk);
        chk("cs_k2", core_start, 0);
        chk("done_cleared", done, 0);
        chk("rst_n_clear", core_reset_n, 0);
        @(negedge clk);
        chk("cs_k3", core_start, 4'hF);
        chk("rst_n_launch", core_reset_n, 4'hF);
        @(negedge clk);
        chk("cs_k4", core_start, 0);
        chk("rst_n_search", core_reset_n, 4'hF);
    endtask

    task automatic wait_and_score(input int exp_lat);
        res_t r;
        int   lat;
        lat = 0;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("done_seen", done, 1);
        chk("latency", lat, exp_lat);
        if (sb.size() == 0) begin
            chk("sb_nonempty", 0, 1);
        end else begin
            r = sb.pop_front();
            chk("key_found", key_found, r.found);
            chk("found_key", found_key, r.key);
            chk("found_core", found_core, r.core);
            chk("rst_n_done", core_reset_n, 0);
            chk("busy_done", busy, 0);
            chk("timeout_done", timeout, 0);
        end
    endtask

    task automatic run_vec(input vec_t v);
        res_t r;
        launch();
        core_key = v.keys;
        r.found  = v.exp_found;
        r.key    = v.exp_key;
        r.core   = v.exp_core;
        sb.push_back(r);
        if (v.stagger) begin
            for (int i = 0; i < N; i++) begin
                core_done = 4'(1 << i);
                core_found = '0;
                @(negedge clk);
                if (i < N - 1) chk("no_done_early", done, 0);
            end
        end else begin
            core_done  = v.dmask;
            core_found = v.fmask;
            @(negedge clk);
        end
        core_done  = '0;
        core_found = '0;
        wait_and_score(0);
        @(negedge clk);
        chk("result_stable", found_key, v.exp_key);
    endtask

    initial begin
        vecs[0] = '{4'b0010, 4'b0010, {24'h0, 24'h0, 24'h1234AB, 24'h0}, 1'b0, 1'b1, 24'h1234AB, 2'd1};
        vecs[1] = '{4'b1100, 4'b1100, {24'h300001, 24'h200005, 24'h0, 24'h0}, 1'b0, 1'b1, 24'h200005, 2'd2};
        vecs[2] = '{4'b1111, 4'b0000, 96'h0, 1'b1, 1'b0, 24'h0, 2'd0};
        vecs[3] = '{4'b1111, 4'b0001, {24'h3FFFFF, 24'h2FFFFF, 24'h1FFFFF, 24'h000777}, 1'b0, 1'b1, 24'h000777, 2'd0};
        vecs[4] = '{4'b0100, 4'b1111, {24'h300009, 24'h2ABCDE, 24'h100002, 24'h000003}, 1'b0, 1'b1, 24'h2ABCDE, 2'd2};

        reset = 1'b1; start = 1'b0;
        core_done = '0; core_found = '0; core_key = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_core_reset_n", core_reset_n, 0);
        chk("rst_core_start", core_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_key_found", key_found, 0);
        chk("rst_found_key", found_key, 0);
        chk("rst_timeout", timeout, 0);

        chk("ks0", core_key_start[0 +: 24], 24'h000000);
        chk("ks2", core_key_start[48 +: 24], 24'h200000);
        chk("ke2", core_key_end[48 +: 24], 24'h2FFFFF);
        chk("ke3", core_key_end[72 +: 24], 24'h3FFFFF);

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Mid-search: start is ignored, then reset aborts without a result.
        launch();
        repeat (10) @(negedge clk);
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (2) @(negedge clk);
        chk("start_ignored_busy", busy, 1);
        chk("start_ignored_done", done, 0);
        chk("start_ignored_cs", core_start, 0);
        reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        chk("mid_rst_reset_n", core_reset_n, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_key_found", key_found, 0);
        chk("mid_rst_found_key", found_key, 0);
        chk("mid_rst_found_core", found_core, 0);
        chk("mid_rst_timeout", timeout, 0);

        run_vec(vecs[1]);

`ifdef SCHED_TIMEOUT_EN
        begin
            int lat;
            launch();
            lat = 0;
            while (!done && lat < 100) begin
                @(negedge clk);
                lat++;
            end
            chk("wd_done", done, 1);
            chk("wd_latency", lat, 50);
            chk("wd_timeout", timeout, 1);
            chk("wd_key_found", key_found, 0);
        end
`else
        launch();
        repeat (60) @(negedge clk);
        chk("no_wd_busy", busy, 1);
        chk("no_wd_timeout", timeout, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
